// File: rtl/volume_ramp_if.sv
// Valid/ready frame bus around the volume stage: upstream side (valid_i/ready_o/data_i)
// and downstream side (valid_o/ready_i/data_o), named from the stage's point of view.
interface volume_ramp_if #(
  parameter int width_p    = 24,
  parameter int channels_p = 2
);
  logic                           valid_i;
  logic                           ready_o;
  logic [channels_p*width_p-1:0]  data_i;
  logic                           valid_o;
  logic                           ready_i;
  logic [channels_p*width_p-1:0]  data_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/volume_ramp.sv
// Multi-channel volume stage: per-channel arithmetic right shift, button-driven target,
// applied shift ramps one step per accepted frame, mute forces silence and max attenuation.
module volume_ramp #(
  parameter int width_p         = 24,
  parameter int channels_p      = 2,
  parameter int min_shift_p     = 0,
  parameter int max_shift_p     = 7,
  parameter int default_shift_p = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  volume_ramp_if.slave                       bus,
  input  logic                               up_i,
  input  logic                               down_i,
  input  logic                               mute_i,
  output logic [$clog2(max_shift_p+1)-1:0]   shift_o,
  output logic                               mute_o
);

  localparam int sw_lp = $clog2(max_shift_p + 1);
  typedef logic [sw_lp-1:0] shift_t;

  localparam shift_t min_lp = shift_t'(min_shift_p);
  localparam shift_t max_lp = shift_t'(max_shift_p);
  localparam shift_t def_lp = shift_t'(default_shift_p);
  localparam shift_t one_lp = shift_t'(1);

  logic                           valid_q, valid_d;
  logic [channels_p*width_p-1:0]  data_q, data_d;
  shift_t                         target_q, target_d;
  shift_t                         applied_q, applied_d;
  logic                           mute_q, mute_d;
  logic                           up_q, down_q, mute_btn_q;

  logic ready, accept;
  logic up_ev, down_ev, mute_ev;

  function automatic logic [width_p-1:0] attenuate(logic [width_p-1:0] s, shift_t sh);
    return $unsigned($signed(s) >>> sh);
  endfunction

  always_comb begin
    ready   = ~valid_q | bus.ready_i;
    accept  = bus.valid_i & ready;
    up_ev   = up_i & ~up_q;
    down_ev = down_i & ~down_q;
    mute_ev = mute_i & ~mute_btn_q;

    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      for (int unsigned k = 0; k < channels_p; k++) begin
        data_d[k*width_p +: width_p] = mute_q ? '0 : attenuate(bus.data_i[k*width_p +: width_p], applied_q);
      end
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end

    target_d = target_q;
    if (up_ev && !down_ev && target_q != min_lp) begin
      target_d = target_q - one_lp;
    end else if (down_ev && !up_ev && target_q != max_lp) begin
      target_d = target_q + one_lp;
    end

    // Ramp uses the pre-edge target; mute pins the applied shift regardless of traffic.
    applied_d = applied_q;
    if (mute_q) begin
      applied_d = max_lp;
    end else if (accept) begin
      if (applied_q < target_q) begin
        applied_d = applied_q + one_lp;
      end else if (applied_q > target_q) begin
        applied_d = applied_q - one_lp;
      end
    end

    mute_d = mute_q ^ mute_ev;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      target_q   <= def_lp;
      applied_q  <= def_lp;
      mute_q     <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      mute_btn_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      target_q   <= target_d;
      applied_q  <= applied_d;
      mute_q     <= mute_d;
      up_q       <= up_i;
      down_q     <= down_i;
      mute_btn_q <= mute_i;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign shift_o     = applied_q;
  assign mute_o      = mute_q;

endmodule

// File: tb/tb_volume_ramp.sv
// Directed and randomized bench for volume_ramp against an arithmetic reference model
// (floor division for attenuation, integer target/applied bookkeeping).
module tb_volume_ramp;
  localparam int W    = 24;
  localparam int C    = 2;
  localparam int MINS = 0;
  localparam int MAXS = 7;
  localparam int DEFS = 3;
  localparam int SW   = $clog2(MAXS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  volume_ramp_if #(.width_p(W), .channels_p(C)) bus ();
  logic          up, down, mute;
  logic [SW-1:0] shift;
  logic          mute_w;

  volume_ramp #(
    .width_p(W), .channels_p(C), .min_shift_p(MINS),
    .max_shift_p(MAXS), .default_shift_p(DEFS)
  ) dut (
    .clk_i(clk), .reset_i(rst_n), .bus(bus),
    .up_i(up), .down_i(down), .mute_i(mute),
    .shift_o(shift), .mute_o(mute_w)
  );

  int tests = 0;
  int fails = 0;

  int           m_target, m_applied;
  bit           m_mute, m_valid;
  logic [C*W-1:0] m_data;
  bit           pu, pd, pm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] atten(input logic [W-1:0] x, input int s);
    longint v, d, q;
    v = longint'($signed(x));
    d = longint'(1) << s;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q[W-1:0];
  endfunction

  function automatic logic [C*W-1:0] rnd_frame();
    logic [C*W-1:0] f;
    for (int k = 0; k < C; k++) f[k*W +: W] = W'($urandom());
    return f;
  endfunction

  task automatic model_reset();
    m_target = DEFS; m_applied = DEFS; m_mute = 0; m_valid = 0;
    m_data = '0; pu = 0; pd = 0; pm = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input bit v, input logic [C*W-1:0] d, input bit r,
                       input bit u, input bit dn, input bit mt);
    bit acc, ue, de, me;
    bus.valid_i = v; bus.data_i = d; bus.ready_i = r;
    up = u; down = dn; mute = mt;
    #1;
    chk("ready_o", 64'(bus.ready_o), 64'(!m_valid || r));
    acc = v && (!m_valid || r);
    @(posedge clk);
    ue = u && !pu; de = dn && !pd; me = mt && !pm;
    pu = u; pd = dn; pm = mt;
    if (acc) begin
      for (int k = 0; k < C; k++)
        m_data[k*W +: W] = m_mute ? '0 : atten(d[k*W +: W], m_applied);
      m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    if (m_mute) m_applied = MAXS;
    else if (acc) begin
      if (m_applied < m_target) m_applied++;
      else if (m_applied > m_target) m_applied--;
    end
    if (ue && !de) m_target = (m_target - 1 < MINS) ? MINS : m_target - 1;
    else if (de && !ue) m_target = (m_target + 1 > MAXS) ? MAXS : m_target + 1;
    if (me) m_mute = !m_mute;
    #1;
    chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
    chk("data_o", 64'(bus.data_o), 64'(m_data));
    chk("shift_o", 64'(shift), 64'(m_applied));
    chk("mute_o", 64'(mute_w), 64'(m_mute));
    @(negedge clk);
  endtask

  logic [C*W-1:0] held;

  initial begin
    bus.valid_i = 0; bus.data_i = '0; bus.ready_i = 0;
    up = 0; down = 0; mute = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_data", 64'(bus.data_o), 64'(0));
    chk("rst_shift", 64'(shift), 64'(3));
    chk("rst_mute", 64'(mute_w), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // first frame
    drive(1, {24'hF00000, 24'h100000}, 1, 0, 0, 0);
    chk("tp1_data", 64'(bus.data_o), 64'(48'hFE0000_020000));
    chk("tp1_valid", 64'(bus.valid_o), 64'(1));
    chk("tp1_shift", 64'(shift), 64'(3));

    // up held while streaming: one event only
    for (int i = 0; i < 5; i++) drive(1, rnd_frame(), 1, 1, 0, 0);
    drive(1, rnd_frame(), 1, 0, 0, 0);
    chk("up_hold_shift", 64'(shift), 64'(2));
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd_frame(), 1, 1, 0, 0);
      drive(1, rnd_frame(), 1, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) drive(1, rnd_frame(), 1, 0, 0, 0);
    chk("up_sat_shift", 64'(shift), 64'(0));

    // ten down pulses with no traffic
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 1, 0, 1, 0);
      drive(0, '0, 1, 0, 0, 0);
    end
    chk("down_idle_shift", 64'(shift), 64'(0));
    for (int i = 0; i < 9; i++) drive(1, rnd_frame(), 1, 0, 0, 0);
    chk("down_sat_shift", 64'(shift), 64'(7));
    drive(1, {24'h000001, 24'h7FFFFF}, 1, 0, 0, 0);
    chk("max_atten_ch0", 64'(bus.data_o[W-1:0]), 64'(24'h00FFFF));

    // backpressure with a pending target change
    drive(1, rnd_frame(), 1, 1, 0, 0);
    held = bus.data_o;
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd_frame(), 0, 0, 0, 0);
      chk("bp_ready", 64'(bus.ready_o), 64'(0));
      chk("bp_data", 64'(bus.data_o), 64'(held));
      chk("bp_shift", 64'(shift), 64'(7));
    end
    drive(1, rnd_frame(), 1, 0, 0, 0);
    chk("bp_resume_shift", 64'(shift), 64'(6));

    // target back to 3, then mute
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 1, 0, 0);
      drive(0, '0, 1, 0, 0, 0);
    end
    drive(0, '0, 1, 0, 0, 1);
    drive(0, '0, 1, 0, 0, 0);
    chk("mute_on", 64'(mute_w), 64'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1, rnd_frame(), 1, 0, 0, 0);
      chk("mute_data", 64'(bus.data_o), 64'(0));
      chk("mute_shift", 64'(shift), 64'(7));
    end
    drive(0, '0, 1, 0, 0, 1);
    drive(0, '0, 1, 0, 0, 0);
    chk("mute_off", 64'(mute_w), 64'(0));
    for (int i = 0; i < 5; i++) begin
      chk("unmute_ramp", 64'(shift), 64'(7 - i));
      drive(1, rnd_frame(), 1, 0, 0, 0);
    end
    chk("unmute_final", 64'(shift), 64'(3));

    // simultaneous up/down events cancel
    drive(0, '0, 1, 1, 1, 0);
    drive(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, rnd_frame(), 1, 0, 0, 0);
    chk("updown_shift", 64'(shift), 64'(3));

    // randomized traffic with occasional buttons
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_frame(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 31) == 0));
    end

    // asynchronous reset while a frame is held
    drive(1, rnd_frame(), 0, 0, 1, 0);
    drive(1, rnd_frame(), 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(bus.valid_o), 64'(0));
    chk("arst_shift", 64'(shift), 64'(3));
    chk("arst_data", 64'(bus.data_o), 64'(0));
    chk("arst_mute", 64'(mute_w), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, {24'hF00000, 24'h100000}, 1, 0, 0, 0);
    chk("post_rst_data", 64'(bus.data_o), 64'(48'hFE0000_020000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/volume_ramp.md
Name: volume_ramp

Overview:
Parametrised multi-channel digital volume stage for the audio path. It attenuates each channel of a packed PCM frame by an arithmetic right shift. Shift changes are driven by debounced up/down/mute buttons. To avoid zipper noise, the applied shift ramps toward the target by at most one step per accepted frame. It sits between the sample source and the codec/serializer, with a valid/ready handshake on both sides.

Parameters:
width_p, 24, bits per channel sample (signed two's complement)
channels_p, 2, channels per frame
min_shift_p, 0, minimum attenuation (loudest), must be >= 0
max_shift_p, 7, maximum attenuation (quietest), must be < width_p
default_shift_p, 3, target and applied shift after reset, min_shift_p <= default_shift_p <= max_shift_p

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-low
valid_i  in  1  input frame valid
ready_o  out  1  block can accept a frame
data_i  in  channels_p*width_p  input frame; channel k occupies bits [k*width_p +: width_p]
valid_o  out  1  output frame valid
ready_i  in  1  downstream accepts the output frame
data_o  out  channels_p*width_p  attenuated frame, same packing as data_i
up_i  in  1  louder button (level input, synchronous to clk_i)
down_i  in  1  quieter button (level input, synchronous to clk_i)
mute_i  in  1  mute toggle button (level input)
shift_o  out  $clog2(max_shift_p+1)  currently applied shift
mute_o  out  1  mute state

Behaviour:
- Reset (reset_i low, asynchronous): target_r=applied_r=default_shift_p, mute_r=0, valid_o=0, data_o=0, all edge-detect registers=0. Reset mid-frame drops the held output frame immediately.
- Edge detect: each button is registered. An event is a rising edge: current=1 and previous=0. A button held high produces exactly one event.
- Target update (every cycle, independent of handshake):
  - up event alone: target_r-1, saturating at min_shift_p.
  - down event alone: target_r+1, saturating at max_shift_p.
  - up and down events in the same cycle: no change.
- Mute: a mute event toggles mute_r. While mute_r=1, applied_r is forced to max_shift_p every cycle and output samples are 0. On unmute, applied_r starts at max_shift_p and ramps toward target_r.
- Handshake:
  - ready_o = ~valid_o | ready_i.
  - Accept = valid_i & ready_o.
  - On accept: for each channel, data_o channel = mute_r ? 0 : (signed data_i channel >>> applied_r); valid_o<=1. The shift used is the applied_r value before this edge.
  - valid_o & ready_i & ~valid_i: valid_o<=0 and data_o holds its value.
  - valid_o=1 & ready_i=0: data_o and valid_o stable; no accept.
- Latency: 1 cycle from accept to valid_o.
- Ramp: applied_r moves one step toward target_r only on an accept edge, after the sample is computed. It never overshoots. It is unchanged when there is no accept, including under backpressure.
- Outputs: shift_o=applied_r; mute_o=mute_r.
- Arithmetic: the shift is sign-preserving, so negative samples round toward -inf. There is no overflow because the shift only attenuates.

Test Plan:
- Reset then accept ch0=0x100000, ch1=0xF00000 -> next cycle valid_o=1, ch0=0x020000, ch1=0xFE0000, shift_o=3, ready_o=1.
- Hold up_i high 5 cycles with frames streaming -> target 2; shift_o goes 3->2 on the next accept and stays 2. Four more up pulses -> target saturates at 0; shift_o steps 2,1,0 one per frame, then holds 0.
- Ten down pulses with no frames -> shift_o stays unchanged. Then stream frames -> shift_o steps one per frame up to 7 and saturates; ch0=0x7FFFFF yields 0x00FFFF.
- Backpressure: valid_o=1, ready_i=0 for 4 cycles with valid_i=1 and a pending target change -> ready_o=0, data_o stable, shift_o unchanged. ready_i=1 -> next frame accepted and the ramp resumes.
- Mute pulse with target 3 -> mute_o=1, outputs 0x000000 for every frame, shift_o=7. Second pulse -> mute_o=0; next five frames use shifts 7,6,5,4,3.
- up_i and down_i rise in the same cycle -> target unchanged. reset_i low while valid_o=1 -> valid_o=0, shift_o=3 immediately without a clock edge.
